// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with debounced press and release detection.
// Emits a one-cycle key_valid per accepted press; key_num holds until the next press.
module keypad_scan #(
   parameter int unsigned SCAN_DIV       = 200000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key_num,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DIV_W = $clog2(SCAN_DIV + 1);
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

   logic [3:0]       col_meta_q, col_sync_q;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       row_idx_q;
   logic [3:0]       row_q;
   logic             acc_found_q;
   logic [3:0]       acc_code_q;
   state_e           state_q;
   logic [DEB_W-1:0] cnt_q;
   logic [3:0]       cand_q;
   logic [3:0]       key_num_q;
   logic             key_valid_q, key_held_q;

   logic             tick, scan_done, row_hit, scan_found;
   logic [1:0]       row_col_idx, next_idx;
   logic [3:0]       scan_code;
   logic [DEB_W-1:0] cnt_inc;

   assign tick      = (div_q == DIV_W'(SCAN_DIV));
   assign scan_done = tick && (row_idx_q == 2'd3);
   assign next_idx  = row_idx_q + 2'd1;
   assign row_hit   = ~&col_sync_q;
   assign cnt_inc   = cnt_q + 1'b1;

   // Lowest-numbered closed column wins within the row being sampled.
   always_comb begin
      // NOTE: default first so every path assigns it and no latch is inferred.
      row_col_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!col_sync_q[i]) row_col_idx = 2'(i);
      end
   end

   // An earlier row in the same scan takes priority over the row-3 sample.
   assign scan_found = acc_found_q | row_hit;
   assign scan_code  = acc_found_q ? acc_code_q : {row_idx_q, row_col_idx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q  <= 4'hF;
         col_sync_q  <= 4'hF;
         div_q       <= DIV_W'(1);
         row_idx_q   <= 2'd0;
         row_q       <= 4'b1110;
         acc_found_q <= 1'b0;
         acc_code_q  <= 4'h0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         col_meta_q <= col;
         col_sync_q <= col_meta_q;
         div_q      <= tick ? DIV_W'(1) : div_q + 1'b1;
         if (tick) begin
            row_idx_q <= next_idx;
            row_q     <= ~(4'b0001 << next_idx);
            if (scan_done) begin
               acc_found_q <= 1'b0;
               acc_code_q  <= 4'h0;
            end else if (!acc_found_q && row_hit) begin
               acc_found_q <= 1'b1;
               acc_code_q  <= {row_idx_q, row_col_idx};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cand_q      <= 4'h0;
         key_num_q   <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (scan_done) begin
            case (state_q)
               IDLE: begin
                  if (scan_found) begin
                     cand_q <= scan_code;
                     if (DEBOUNCE_SCANS == 1) begin
                        state_q     <= PRESSED;
                        key_num_q   <= scan_code;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                     end else begin
                        state_q <= DEBOUNCE;
                        cnt_q   <= DEB_W'(1);
                     end
                  end
               end
               DEBOUNCE: begin
                  if (scan_found && scan_code == cand_q) begin
                     if (cnt_inc == DEB_W'(DEBOUNCE_SCANS)) begin
                        state_q     <= PRESSED;
                        cnt_q       <= '0;
                        key_num_q   <= cand_q;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                     end else begin
                        cnt_q <= cnt_inc;
                     end
                  end else begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end
               end
               PRESSED: begin
                  if (!scan_found) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        state_q    <= IDLE;
                        key_held_q <= 1'b0;
                     end else begin
                        state_q <= RELEASE;
                        cnt_q   <= DEB_W'(1);
                     end
                  end
               end
               RELEASE: begin
                  if (scan_found) begin
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                  end else if (cnt_inc == DEB_W'(DEBOUNCE_SCANS)) begin
                     state_q    <= IDLE;
                     cnt_q      <= '0;
                     key_held_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign row       = row_q;
   assign key_num   = key_num_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a vector table of whole scans, reset and
// mid-debounce reset sequences, then random key activity against a scan-level model.
module tb_keypad_scan;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int SCAN_CLK = 4 * SCAN_DIV;

   typedef struct packed {
      logic [15:0] mask;
      logic        valid;
      logic        held;
      logic [3:0]  num;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  key_num;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys = '0;

   int total  = 0;
   int bad    = 0;
   int pulses = 0;

   // Scan-level reference state: pressed-key flag plus streak/gap counters.
   bit       m_held;
   int       m_streak, m_gap, m_cand;
   logic [3:0] m_num;

   vec_t vecs[$];
   logic [3:0] exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .col(col), .row(row),
      .key_num(key_num), .key_valid(key_valid), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a closed key pulls its column low while its row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
   end

   always @(negedge clk) if (key_valid) pulses++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_streak = 0; m_gap = 0; m_cand = 0; m_num = 4'h0;
   endtask

   // Scan result = lowest closed key index, which equals {row, col} priority order.
   task automatic model_scan(input logic [15:0] mask, output bit pulse);
      int code;
      code  = -1;
      pulse = 0;
      for (int i = 0; i < 16; i++) if (mask[i] && code < 0) code = i;
      if (!m_held) begin
         if (code < 0)              m_streak = 0;
         else if (m_streak == 0)    begin m_streak = 1; m_cand = code; end
         else if (code == m_cand)   m_streak++;
         else                       m_streak = 0;
         if (m_streak == DEB) begin
            m_held = 1; m_num = 4'(m_cand); pulse = 1; m_streak = 0;
         end
      end else if (code >= 0) begin
         m_gap = 0;
      end else begin
         m_gap++;
         if (m_gap == DEB) begin m_held = 0; m_gap = 0; end
      end
   endtask

   task automatic scan_and_check(input logic [15:0] mask, input logic ev, input logic eh,
                                 input logic [3:0] en, input string tag);
      int p0;
      p0   = pulses;
      keys = mask;
      repeat (SCAN_CLK) @(posedge clk);
      @(negedge clk); #1;
      check({tag, " key_valid"}, key_valid, ev);
      check({tag, " key_held"},  key_held,  eh);
      check({tag, " key_num"},   key_num,   en);
      check({tag, " row"},       row,       4'b1110);
      check({tag, " pulses"},    pulses - p0, ev);
   endtask

   task automatic reset_dut(input logic [15:0] mask, input string tag);
      int p0;
      bit p;
      p0    = pulses;
      keys  = mask;
      rst_n = 1'b0;
      #1;
      check({tag, " rst row"},       row,       4'b1110);
      check({tag, " rst key_num"},   key_num,   4'h0);
      check({tag, " rst key_valid"}, key_valid, 1'b0);
      check({tag, " rst key_held"},  key_held,  1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         repeat (SCAN_DIV) @(posedge clk);
         #1;
         check({tag, " row step"}, row, exp_rows[i]);
      end
      @(negedge clk); #1;
      model_reset();
      model_scan(mask, p);
      check({tag, " first scan key_valid"}, key_valid, p);
      check({tag, " first scan key_held"},  key_held,  m_held);
      check({tag, " first scan key_num"},   key_num,   m_num);
      check({tag, " reset pulses"},         pulses - p0, p);
   endtask

   initial begin
      bit p;
      logic [15:0] mask, prev;

      // Whole-scan vectors starting from IDLE with key_num=0.
      vecs.push_back('{16'h0200, 1'b0, 1'b0, 4'h0});   // one-scan bounce
      vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'h0});
      vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'h0});
      vecs.push_back('{16'h0200, 1'b0, 1'b0, 4'h0});   // row2/col1 held
      vecs.push_back('{16'h0200, 1'b0, 1'b0, 4'h0});
      vecs.push_back('{16'h0200, 1'b1, 1'b1, 4'h9});
      for (int i = 0; i < 10; i++) vecs.push_back('{16'h0200, 1'b0, 1'b1, 4'h9});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'h9});   // one-scan release glitch
      vecs.push_back('{16'h0200, 1'b0, 1'b1, 4'h9});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'h9});   // real release
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'h9});
      vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0180, 1'b0, 1'b0, 4'h9});   // row1/col3 + row2/col0
      vecs.push_back('{16'h0180, 1'b0, 1'b0, 4'h9});
      vecs.push_back('{16'h0180, 1'b1, 1'b1, 4'h7});
      vecs.push_back('{16'h0200, 1'b0, 1'b1, 4'h7});   // other key while pressed
      vecs.push_back('{16'h0200, 1'b0, 1'b1, 4'h7});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'h7});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'h7});
      vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'h7});
      vecs.push_back('{16'h0001, 1'b0, 1'b0, 4'h7});   // candidate changes mid-debounce
      vecs.push_back('{16'h0002, 1'b0, 1'b0, 4'h7});
      vecs.push_back('{16'h0002, 1'b0, 1'b0, 4'h7});
      vecs.push_back('{16'h0002, 1'b0, 1'b0, 4'h7});
      vecs.push_back('{16'h0002, 1'b1, 1'b1, 4'h1});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'h1});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'h1});
      vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'h1});
      vecs.push_back('{16'h8000, 1'b0, 1'b0, 4'h1});   // last key, row 3
      vecs.push_back('{16'h8000, 1'b0, 1'b0, 4'h1});
      vecs.push_back('{16'h8000, 1'b1, 1'b1, 4'hF});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'hF});
      vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'hF});
      vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'hF});

      #2;
      reset_dut(16'h0000, "init");

      for (int i = 0; i < vecs.size(); i++) begin
         model_scan(vecs[i].mask, p);
         scan_and_check(vecs[i].mask, vecs[i].valid, vecs[i].held, vecs[i].num,
                        $sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of a debounce with the key still closed.
      model_scan(16'h0200, p);
      scan_and_check(16'h0200, 1'b0, 1'b0, 4'hF, "pre-reset debounce");
      repeat (7) @(posedge clk);
      #2;
      reset_dut(16'h0200, "mid reset");
      model_scan(16'h0200, p);
      scan_and_check(16'h0200, 1'b0, 1'b0, 4'h0, "post-reset scan2");
      model_scan(16'h0200, p);
      scan_and_check(16'h0200, 1'b1, 1'b1, 4'h9, "post-reset scan3");

      // Random key activity, biased toward keys staying put for several scans.
      prev = 16'h0200;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0, 1:          mask = 16'h0000;
            2, 3, 4, 5, 6: mask = prev;
            default: begin
               mask = 16'(1) << $urandom_range(0, 15);
               if ($urandom_range(0, 3) == 0) mask = mask | (16'(1) << $urandom_range(0, 15));
            end
         endcase
         prev = mask;
         model_scan(mask, p);
         scan_and_check(mask, p, m_held, m_num, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
